// File: rtl/eviction_write_buffer_if.sv
// Bus bundle between the eviction write buffer, its cache controller and physical memory.
// master = environment side (cache + pmem), slave = the buffer itself.
interface eviction_write_buffer_if #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned SIZE_W = $clog2(DEPTH) + 1;

    logic              evict_valid;
    logic [31:0]       evict_addr;
    logic [WIDTH-1:0]  evict_data;
    logic              evict_ready;
    logic              ewb_access;
    logic [SIZE_W-1:0] ewb_size;
    logic [31:0]       lookup_addr;
    logic              lookup_hit;
    logic [WIDTH-1:0]  lookup_data;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [WIDTH-1:0]  pmem_wdata;
    logic              pmem_resp;

    modport master (
        output evict_valid, evict_addr, evict_data, ewb_access, lookup_addr, pmem_resp,
        input  evict_ready, ewb_size, lookup_hit, lookup_data, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  evict_valid, evict_addr, evict_data, ewb_access, lookup_addr, pmem_resp,
        output evict_ready, ewb_size, lookup_hit, lookup_data, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/eviction_write_buffer.sv
// FIFO of dirty victim lines: coalesces re-evictions, serves refills, drains oldest-first to pmem.
module eviction_write_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WIDTH    = 256,
    parameter int unsigned S_OFFSET = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    eviction_write_buffer_if.slave     bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TAG_W = 32 - S_OFFSET;

    typedef enum logic {IDLE, WRITE} state_t;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    state_t           state_q;

    logic             pmem_write_q;
    logic [31:0]      pmem_address_q;
    logic [WIDTH-1:0] pmem_wdata_q;

    logic [TAG_W-1:0] evict_tag;
    logic [TAG_W-1:0] lookup_tag;
    logic             full;
    logic             coal_hit;
    logic [PTR_W-1:0] coal_idx;
    logic             push_alloc;
    logic             push_coal;
    logic             resp_fire;
    logic             start;
    logic             lk_hit;
    logic [WIDTH-1:0] lk_data;
    logic [PTR_W-1:0] lk_idx;
    logic             unused_low_bits;

    assign evict_tag       = bus.evict_addr[31:S_OFFSET];
    assign lookup_tag      = bus.lookup_addr[31:S_OFFSET];
    assign unused_low_bits = ^{bus.evict_addr[S_OFFSET-1:0], bus.lookup_addr[S_OFFSET-1:0]};

    assign full       = (count_q == CNT_W'(DEPTH));
    assign push_alloc = bus.evict_valid && !coal_hit && !full;
    assign push_coal  = bus.evict_valid && coal_hit;
    assign resp_fire  = (state_q == WRITE) && bus.pmem_resp;
    assign start      = (state_q == IDLE) && (count_q != '0) && (bus.ewb_access || full);

    // Coalesce target: a valid entry with the same line that is not currently being written.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (tag_q[i] == evict_tag) &&
                !((state_q == WRITE) && (PTR_W'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    // Refill lookup: walk oldest to newest so the newest match overrides older ones.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_idx  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            lk_idx = head_q + PTR_W'(k);
            if (valid_q[lk_idx] && (tag_q[lk_idx] == lookup_tag)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[lk_idx];
            end
        end
    end

    // Line storage: allocate at tail, or overwrite the coalesce target's data.
    always_ff @(posedge clk) begin
        if (push_alloc) begin
            tag_q[tail_q]  <= evict_tag;
            data_q[tail_q] <= bus.evict_data;
        end else if (push_coal) begin
            data_q[coal_idx] <= bus.evict_data;
        end
    end

    // Pointers, occupancy, valid bits and the drain FSM with its registered pmem outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            state_q        <= IDLE;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            if (push_alloc) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (resp_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            case ({push_alloc, resp_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q        <= WRITE;
                        pmem_write_q   <= 1'b1;
                        pmem_address_q <= {tag_q[head_q], {S_OFFSET{1'b0}}};
                        // A same-cycle coalesce into the head must not be lost.
                        pmem_wdata_q   <= (push_coal && (coal_idx == head_q)) ?
                                          bus.evict_data : data_q[head_q];
                    end
                end
                WRITE: begin
                    if (bus.pmem_resp) begin
                        state_q      <= IDLE;
                        pmem_write_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.evict_ready  = !full;
    assign bus.ewb_size     = count_q;
    assign bus.lookup_hit   = lk_hit;
    assign bus.lookup_data  = lk_data;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed bench for eviction_write_buffer: reset, fill/auto-drain, coalescing, in-flight match, wrap.
module tb_eviction_write_buffer;
    localparam int unsigned W = 256;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    eviction_write_buffer_if #(.WIDTH(W), .DEPTH(4)) bus ();

    eviction_write_buffer #(.DEPTH(4), .WIDTH(W), .S_OFFSET(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] mk(input logic [31:0] a, input logic [7:0] v);
        return {8{a[23:0], v}};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [W-1:0] d);
        bus.evict_valid = 1'b1;
        bus.evict_addr  = a;
        bus.evict_data  = d;
        tick();
        bus.evict_valid = 1'b0;
    endtask

    // Request a drain, wait (bounded) for the write strobe, check it, then acknowledge.
    task automatic drain_expect(input string tag, input logic [31:0] a, input logic [W-1:0] d);
        int n;
        n = 0;
        bus.ewb_access = 1'b1;
        do begin
            tick();
            n++;
        end while (!bus.pmem_write && n < 20);
        bus.ewb_access = 1'b0;
        chk({tag, "_write"}, W'(bus.pmem_write), W'(1'b1));
        chk({tag, "_addr"}, W'(bus.pmem_address), W'(a));
        chk({tag, "_data"}, bus.pmem_wdata, d);
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        bus.evict_valid = 1'b0;
        bus.evict_addr  = '0;
        bus.evict_data  = '0;
        bus.ewb_access  = 1'b0;
        bus.lookup_addr = '0;
        bus.pmem_resp   = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset values
        chk("rst_pmem_write", W'(bus.pmem_write), W'(0));
        chk("rst_pmem_address", W'(bus.pmem_address), W'(0));
        chk("rst_pmem_wdata", bus.pmem_wdata, W'(0));
        chk("rst_ewb_size", W'(bus.ewb_size), W'(0));
        chk("rst_evict_ready", W'(bus.evict_ready), W'(1));
        chk("rst_lookup_hit", W'(bus.lookup_hit), W'(0));
        chk("rst_lookup_data", bus.lookup_data, W'(0));

        // 1: reset asserted mid-write drops pmem_write immediately
        push(32'h0000_0100, mk(32'h100, 8'h01));
        bus.ewb_access = 1'b1;
        tick();
        bus.ewb_access = 1'b0;
        chk("t1_write_started", W'(bus.pmem_write), W'(1));
        rst = 1'b0;
        #1;
        chk("t1_write_dropped", W'(bus.pmem_write), W'(0));
        tick();
        rst = 1'b1;
        tick();
        chk("t1_size_after", W'(bus.ewb_size), W'(0));
        chk("t1_ready_after", W'(bus.evict_ready), W'(1));
        bus.lookup_addr = 32'h0000_0100;
        #1;
        chk("t1_lost_line", W'(bus.lookup_hit), W'(0));

        // 2: fill to DEPTH, coalesce while full, auto-drain with slow response
        for (int i = 0; i < 4; i++)
            push(32'h0000_0400 + 32'(i) * 32'h20, mk(32'h400 + 32'(i) * 32'h20, 8'h10));
        chk("t2_size_full", W'(bus.ewb_size), W'(4));
        chk("t2_ready_full", W'(bus.evict_ready), W'(0));
        push(32'h0000_0440, mk(32'h440, 8'hEE));
        chk("t2_size_coal_full", W'(bus.ewb_size), W'(4));
        chk("t2_auto_write", W'(bus.pmem_write), W'(1));
        chk("t2_auto_addr", W'(bus.pmem_address), W'(32'h0000_0400));
        chk("t2_auto_data", bus.pmem_wdata, mk(32'h400, 8'h10));
        tick();
        tick();
        tick();
        chk("t2_hold_write", W'(bus.pmem_write), W'(1));
        chk("t2_hold_addr", W'(bus.pmem_address), W'(32'h0000_0400));
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        chk("t2_size_after_resp", W'(bus.ewb_size), W'(3));
        chk("t2_write_low", W'(bus.pmem_write), W'(0));
        drain_expect("t2_a1", 32'h0000_0420, mk(32'h420, 8'h10));
        drain_expect("t2_a2", 32'h0000_0440, mk(32'h440, 8'hEE));
        drain_expect("t2_a3", 32'h0000_0460, mk(32'h460, 8'h10));
        chk("t2_size_empty", W'(bus.ewb_size), W'(0));

        // 3: coalesce into a waiting entry
        push(32'h0000_1000, mk(32'h1000, 8'hD1));
        push(32'h0000_1000, mk(32'h1000, 8'hD2));
        chk("t3_size", W'(bus.ewb_size), W'(1));
        bus.lookup_addr = 32'h0000_1004;
        #1;
        chk("t3_hit", W'(bus.lookup_hit), W'(1));
        chk("t3_lookup_data", bus.lookup_data, mk(32'h1000, 8'hD2));
        drain_expect("t3_drain", 32'h0000_1000, mk(32'h1000, 8'hD2));
        chk("t3_size_empty", W'(bus.ewb_size), W'(0));

        // 4: push matching the in-flight head allocates a new entry
        push(32'h0000_2000, mk(32'h2000, 8'hD1));
        bus.ewb_access = 1'b1;
        tick();
        bus.ewb_access = 1'b0;
        chk("t4_writing", W'(bus.pmem_write), W'(1));
        push(32'h0000_2000, mk(32'h2000, 8'hD2));
        chk("t4_size", W'(bus.ewb_size), W'(2));
        bus.lookup_addr = 32'h0000_2000;
        #1;
        chk("t4_hit", W'(bus.lookup_hit), W'(1));
        chk("t4_lookup_newest", bus.lookup_data, mk(32'h2000, 8'hD2));
        chk("t4_inflight_data", bus.pmem_wdata, mk(32'h2000, 8'hD1));
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        chk("t4_size_after", W'(bus.ewb_size), W'(1));
        drain_expect("t4_second", 32'h0000_2000, mk(32'h2000, 8'hD2));

        // 5: simultaneous push and pmem_resp at count 3
        for (int i = 0; i < 3; i++)
            push(32'h0000_3000 + 32'(i) * 32'h20, mk(32'h3000 + 32'(i) * 32'h20, 8'h50));
        bus.ewb_access = 1'b1;
        tick();
        bus.ewb_access = 1'b0;
        chk("t5_write_b0", W'(bus.pmem_address), W'(32'h0000_3000));
        bus.evict_valid = 1'b1;
        bus.evict_addr  = 32'h0000_3060;
        bus.evict_data  = mk(32'h3060, 8'h50);
        bus.pmem_resp   = 1'b1;
        tick();
        bus.evict_valid = 1'b0;
        bus.pmem_resp   = 1'b0;
        chk("t5_size_same", W'(bus.ewb_size), W'(3));
        for (int i = 1; i < 4; i++)
            drain_expect("t5_order", 32'h0000_3000 + 32'(i) * 32'h20,
                         mk(32'h3000 + 32'(i) * 32'h20, 8'h50));
        chk("t5_size_empty", W'(bus.ewb_size), W'(0));

        // 6: ten push/drain pairs wrap the pointers
        for (int i = 0; i < 10; i++) begin
            push(32'h0000_8000 + 32'(i) * 32'h40, mk(32'h8000 + 32'(i) * 32'h40, 8'(i)));
            drain_expect("t6_wrap", 32'h0000_8000 + 32'(i) * 32'h40,
                         mk(32'h8000 + 32'(i) * 32'h40, 8'(i)));
        end
        chk("t6_size_empty", W'(bus.ewb_size), W'(0));
        bus.lookup_addr = 32'h0000_8000;
        #1;
        chk("t6_miss_hit", W'(bus.lookup_hit), W'(0));
        chk("t6_miss_data", bus.lookup_data, W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
